// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and sizing helper for the VGA timing generator.
//   - Standard mode timings (640x480@60 and 800x600@60): porch, sync, active
//     widths and sync polarities.
//   - total_bits(): counter width needed to hold 0..total-1.
package vga_pkg;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_H_POL    = 1'b0;
  localparam bit VGA640_V_POL    = 1'b0;

  // 800x600 @ 60 Hz (40 MHz pixel clock), positive syncs
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;
  localparam bit VGA800_H_POL    = 1'b1;
  localparam bit VGA800_V_POL    = 1'b1;

  // Bits needed for a counter running 0..total-1 (at least 1 bit).
  function automatic int total_bits(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one axis (horizontal or vertical) of the VGA raster.
//   Counts 0..TOTAL-1, flags the wrap, decodes the active region and keeps a
//   registered sync output.
// Ports:
//   i_clock    system clock
//   i_reset    synchronous active-high reset (count 0, sync idle)
//   i_advance  step the counter this cycle
//   i_sample   register sync from the current count this cycle
//   o_count    current position
//   o_wrap     i_advance while at TOTAL-1 (counter returns to 0 next edge)
//   o_active   count < ACTIVE, combinational
//   o_sync     registered sync, POL inside the sync window, ~POL elsewhere
module vga_axis_counter import vga_pkg::*; #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int W      = total_bits(ACTIVE + FP + SYNC + BP)
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_advance,
  input  logic         i_sample,
  output logic [W-1:0] o_count,
  output logic         o_wrap,
  output logic         o_active,
  output logic         o_sync
);

  localparam int TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_BEG = ACTIVE + FP;
  localparam int SYNC_END = ACTIVE + FP + SYNC;

  // Bounds that equal TOTAL do not fit in W bits; those cases are resolved
  // by the *_OPEN / *_NONE flags instead of a truncated compare.
  localparam bit ACT_OPEN  = (ACTIVE >= TOTAL);
  localparam bit SYNC_NONE = (SYNC == 0) || (SYNC_BEG >= TOTAL);
  localparam bit SYNC_OPEN = (SYNC_END >= TOTAL);

  localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_HI = ACT_OPEN  ? '0 : W'(ACTIVE);
  localparam logic [W-1:0] SYN_LO = SYNC_NONE ? '0 : W'(SYNC_BEG);
  localparam logic [W-1:0] SYN_HI = SYNC_OPEN ? '0 : W'(SYNC_END);

  logic [W-1:0] count_q, count_d;
  logic         sync_q, sync_d;
  logic         at_last;
  logic         in_active;
  logic         in_sync;

  assign at_last   = (count_q == LAST);
  assign in_active = ACT_OPEN || (count_q < ACT_HI);
  assign in_sync   = !SYNC_NONE && (count_q >= SYN_LO) &&
                     (SYNC_OPEN || (count_q < SYN_HI));

  always_comb begin
    count_d = count_q;
    sync_d  = sync_q;
    if (i_advance) begin
      count_d = at_last ? '0 : count_q + W'(1);
    end
    if (i_sample) begin
      sync_d = in_sync ? POL : ~POL;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign o_count  = count_q;
  assign o_wrap   = i_advance && at_last;
  assign o_active = in_active;
  assign o_sync   = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator with registered,
// blanked colour path.
//   A pixel-enable divider produces o_pix_tick; two vga_axis_counter
//   instances hold the raster position. Sync and colour are registered on the
//   tick from the current o_x/o_y, so both lag the coordinates by one pixel
//   and stay aligned with each other.
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_enable                  run enable; low freezes everything
//   i_red/i_green/i_blue      pixel colour for the current o_x/o_y
//   i_pattern_sel             (only with VGA_TIMING_TEST_PATTERN_EN) select
//                             the built-in 8-bar test pattern
//   o_x, o_y                  raster coordinates
//   o_active                  coordinates inside the visible area
//   o_pix_tick                pulse on the cycles the coordinates advance
//   o_line_start              tick on which o_x wraps to 0
//   o_frame_start             tick on which o_x and o_y both wrap to 0
//   o_hsync, o_vsync          registered syncs
//   o_red/o_green/o_blue      registered colour, zero outside the active area
// Optional build macro: VGA_TIMING_TEST_PATTERN_EN (adds i_pattern_sel).
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int H_FP       = VGA640_H_FP,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BP       = VGA640_H_BP,
  parameter int V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int V_FP       = VGA640_V_FP,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BP       = VGA640_V_BP,
  parameter bit H_POL      = VGA640_H_POL,
  parameter bit V_POL      = VGA640_V_POL,
  parameter int COLOR_BITS = 3,
  parameter int CLK_DIV    = 1,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW        = total_bits(H_TOTAL),
  localparam int YW        = total_bits(V_TOTAL)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [COLOR_BITS-1:0] i_red,
  input  logic [COLOR_BITS-1:0] i_green,
  input  logic [COLOR_BITS-1:0] i_blue,
`ifdef VGA_TIMING_TEST_PATTERN_EN
  input  logic                  i_pattern_sel,
`endif
  output logic [XW-1:0]         o_x,
  output logic [YW-1:0]         o_y,
  output logic                  o_active,
  output logic                  o_pix_tick,
  output logic                  o_line_start,
  output logic                  o_frame_start,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic [COLOR_BITS-1:0] o_red,
  output logic [COLOR_BITS-1:0] o_green,
  output logic [COLOR_BITS-1:0] o_blue
);

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]         div_q, div_d;
  logic                  pix_tick;
  logic                  h_wrap, v_wrap;
  logic                  h_active, v_active;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [COLOR_BITS-1:0] src_red, src_green, src_blue;
  logic [COLOR_BITS-1:0] red_q, red_d;
  logic [COLOR_BITS-1:0] green_q, green_d;
  logic [COLOR_BITS-1:0] blue_q, blue_d;

  // Gated by reset so no strobe escapes while the raster is being cleared.
  assign pix_tick = i_enable && !i_reset && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (i_enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .W      (XW)
  ) u_h_axis (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_advance (pix_tick),
    .i_sample  (pix_tick),
    .o_count   (x),
    .o_wrap    (h_wrap),
    .o_active  (h_active),
    .o_sync    (o_hsync)
  );

  // The vertical count steps once per line, but vsync is sampled on every
  // tick so it carries the same one-pixel latency as hsync and colour.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .W      (YW)
  ) u_v_axis (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_advance (h_wrap),
    .i_sample  (pix_tick),
    .o_count   (y),
    .o_wrap    (v_wrap),
    .o_active  (v_active),
    .o_sync    (o_vsync)
  );

`ifdef VGA_TIMING_TEST_PATTERN_EN
  // Bar index = x*8/H_ACTIVE; only meaningful inside the active area, the
  // blanking below hides the out-of-range values.
  localparam int PW = XW + 3;
  logic [PW-1:0] x_scaled;
  logic [2:0]    bar;

  always_comb begin
    x_scaled = {x, 3'b000};
    bar      = 3'(x_scaled / PW'(H_ACTIVE));
  end

  assign src_red   = i_pattern_sel ? {COLOR_BITS{bar[2]}} : i_red;
  assign src_green = i_pattern_sel ? {COLOR_BITS{bar[1]}} : i_green;
  assign src_blue  = i_pattern_sel ? {COLOR_BITS{bar[0]}} : i_blue;
`else
  assign src_red   = i_red;
  assign src_green = i_green;
  assign src_blue  = i_blue;
`endif

  always_comb begin
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (pix_tick) begin
      red_d   = o_active ? src_red   : '0;
      green_d = o_active ? src_green : '0;
      blue_d  = o_active ? src_blue  : '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      div_q   <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      div_q   <= div_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign o_x           = x;
  assign o_y           = y;
  assign o_active      = h_active && v_active;
  assign o_pix_tick    = pix_tick;
  assign o_line_start  = h_wrap;
  assign o_frame_start = v_wrap;
  assign o_red         = red_q;
  assign o_green       = green_q;
  assign o_blue        = blue_q;

endmodule
